// File: rtl/saes_pkg.sv
// saes_pkg: shared S-AES definitions for the byte-serial encode/decode cores.
//   - FSM state enum for the decoder
//   - round constants, nibble S-box tables
//   - GF(2^4) helpers and the inverse row/column transforms
package saes_pkg;

  localparam int BLK_W   = 16;
  localparam int KEY_W   = 16;
  localparam int BYTE_W  = 8;
  localparam int NIB_W   = 4;
  localparam int NUM_NIB = BLK_W / NIB_W;

  localparam logic [BYTE_W-1:0] RCON1 = 8'h80;
  localparam logic [BYTE_W-1:0] RCON2 = 8'h30;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_LO = 3'd1,
    KEYEXP  = 3'd2,
    RND2    = 3'd3,
    RND1    = 3'd4,
    FINAL   = 3'd5
  } state_e;

  // Expanded round keys, K0 applied last on the decode path.
  typedef struct packed {
    logic [BLK_W-1:0] k0;
    logic [BLK_W-1:0] k1;
    logic [BLK_W-1:0] k2;
  } rkeys_t;

  // Element i of each table is the substitution of nibble value i.
  localparam logic [15:0][NIB_W-1:0] SBOX = {
    4'h7, 4'hF, 4'hE, 4'hC, 4'h3, 4'h0, 4'h2, 4'h6,
    4'h5, 4'h8, 4'h1, 4'hD, 4'hB, 4'hA, 4'h4, 4'h9
  };
  localparam logic [15:0][NIB_W-1:0] INV_SBOX = {
    4'hE, 4'hD, 4'h4, 4'hC, 4'h3, 4'h2, 4'h0, 4'h6,
    4'hF, 4'h8, 4'h7, 4'h1, 4'hB, 4'h9, 4'h5, 4'hA
  };

  // x * a mod (x^4 + x + 1)
  function automatic logic [NIB_W-1:0] gf4_mul2(input logic [NIB_W-1:0] a);
    return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  // 9a = 8a ^ a
  function automatic logic [NIB_W-1:0] gf4_mul9(input logic [NIB_W-1:0] a);
    return gf4_mul2(gf4_mul2(gf4_mul2(a))) ^ a;
  endfunction

  // Row 1 of the 2x2 nibble matrix is (n1, n3); shifting it is a swap,
  // so forward and inverse ShiftRows are the same permutation.
  function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

  // Columns are (n0,n1) and (n2,n3): a' = 9a ^ 2b, b' = 2a ^ 9b.
  function automatic logic [BLK_W-1:0] inv_mix_col(input logic [BLK_W-1:0] s);
    return {gf4_mul9(s[15:12]) ^ gf4_mul2(s[11:8]),
            gf4_mul2(s[15:12]) ^ gf4_mul9(s[11:8]),
            gf4_mul9(s[7:4])   ^ gf4_mul2(s[3:0]),
            gf4_mul2(s[7:4])   ^ gf4_mul9(s[3:0])};
  endfunction

  function automatic logic [BYTE_W-1:0] rot_nib(input logic [BYTE_W-1:0] w);
    return {w[3:0], w[7:4]};
  endfunction

endpackage

// File: rtl/saes_nibble_sbox.sv
// saes_nibble_sbox: single 4-bit S-AES substitution, forward or inverse.
//   nib_i  in   4  nibble to substitute
//   inv_i  in   1  0 = forward SubNib, 1 = InvSubNib
//   nib_o  out  4  substituted nibble
module saes_nibble_sbox
  import saes_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  input  logic             inv_i,
  output logic [NIB_W-1:0] nib_o
);

  assign nib_o = inv_i ? INV_SBOX[nib_i] : SBOX[nib_i];

endmodule

// File: rtl/saes_decode_core.sv
// saes_decode_core: byte-serial S-AES decryption engine (16-bit block/key,
// 2 rounds). Ciphertext and key arrive high byte then low byte; key expansion
// takes one cycle, each inverse round one cycle, final key add one cycle.
//   in_clka           in   1   clock
//   in_restart        in   1   synchronous active-high reset
//   in_enable_decode  in   1   byte-load strobe (IDLE / LOAD_LO only)
//   in_c_in           in   8   ciphertext byte
//   in_key_in         in   8   key byte
//   out_data          out  16  plaintext, held until next result or reset
//   out_valid         out  1   one-cycle pulse when out_data updates
//   out_busy          out  1   high whenever the FSM is not IDLE
module saes_decode_core
  import saes_pkg::*;
(
  input  logic              in_clka,
  input  logic              in_restart,
  input  logic              in_enable_decode,
  input  logic [BYTE_W-1:0] in_c_in,
  input  logic [BYTE_W-1:0] in_key_in,
  output logic [BLK_W-1:0]  out_data,
  output logic              out_valid,
  output logic              out_busy
);

  state_e           state_q, state_d;
  logic [BLK_W-1:0] ct_q;
  logic [KEY_W-1:0] key_q;
  rkeys_t           rk_q;
  logic [BLK_W-1:0] s_q;
  logic [BLK_W-1:0] out_data_q;
  logic             out_valid_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge in_clka) begin
    if (in_restart) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_enable_decode) state_d = LOAD_LO;
      LOAD_LO: if (in_enable_decode) state_d = KEYEXP;
      KEYEXP:  state_d = RND2;
      RND2:    state_d = RND1;
      RND1:    state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_busy = (state_q != IDLE);
  end

  // ------------------------------------------------------ key expansion
  // Two independent S-box pairs: the second pair's input depends on the
  // first pair's output, so they stay separate signals to keep the
  // combinational chain acyclic.
  logic [BYTE_W-1:0]           w0, w1, w2, w3, w4, w5;
  logic [1:0][NIB_W-1:0]       g1_in, g1_out, g3_in, g3_out;

  assign w0    = key_q[15:8];
  assign w1    = key_q[7:0];
  assign g1_in = rot_nib(w1);
  assign w2    = w0 ^ RCON1 ^ g1_out;
  assign w3    = w2 ^ w1;
  assign g3_in = rot_nib(w3);
  assign w4    = w2 ^ RCON2 ^ g3_out;
  assign w5    = w4 ^ w3;

  for (genvar g = 0; g < 2; g++) begin : g_kx1
    saes_nibble_sbox u_sbox (.nib_i(g1_in[g]), .inv_i(1'b0), .nib_o(g1_out[g]));
  end
  for (genvar g = 0; g < 2; g++) begin : g_kx3
    saes_nibble_sbox u_sbox (.nib_i(g3_in[g]), .inv_i(1'b0), .nib_o(g3_out[g]));
  end

  // -------------------------------------------------- shared round logic
  // RND2 consumes ct ^ K2; RND1 consumes InvMixCol(s ^ K1). Both then go
  // through InvShiftRows and InvSubNib on the same four S-boxes.
  logic [BLK_W-1:0]                rnd_x;
  logic [NUM_NIB-1:0][NIB_W-1:0]   rnd_pre, rnd_sub;

  assign rnd_x   = (state_q == RND2) ? (ct_q ^ rk_q.k2)
                                     : inv_mix_col(s_q ^ rk_q.k1);
  assign rnd_pre = inv_shift_rows(rnd_x);

  for (genvar g = 0; g < NUM_NIB; g++) begin : g_rnd
    saes_nibble_sbox u_sbox (.nib_i(rnd_pre[g]), .inv_i(1'b1), .nib_o(rnd_sub[g]));
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      ct_q        <= '0;
      key_q       <= '0;
      rk_q        <= '0;
      s_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: if (in_enable_decode) begin
          ct_q[15:8]  <= in_c_in;
          key_q[15:8] <= in_key_in;
        end
        LOAD_LO: if (in_enable_decode) begin
          ct_q[7:0]  <= in_c_in;
          key_q[7:0] <= in_key_in;
        end
        KEYEXP: begin
          rk_q.k0 <= {w0, w1};
          rk_q.k1 <= {w2, w3};
          rk_q.k2 <= {w4, w5};
        end
        RND2, RND1: s_q <= rnd_sub;
        FINAL: begin
          out_data_q  <= s_q ^ rk_q.k0;
          out_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_saes_decode_core.sv
module tb_saes_decode_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  c_in, k_in;
  logic [15:0] out_data;
  logic        out_valid, out_busy;

  saes_decode_core dut (
    .in_clka(clk), .in_restart(rst), .in_enable_decode(en),
    .in_c_in(c_in), .in_key_in(k_in),
    .out_data(out_data), .out_valid(out_valid), .out_busy(out_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] data; int due; } exp_t;
  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic prev_valid = 1'b0;

  // ---------------- reference encryption model
  logic [3:0] sbx [16] = '{4'h9,4'h4,4'hA,4'hB,4'hD,4'h1,4'h8,4'h5,
                           4'h6,4'h2,4'h0,4'h3,4'hC,4'hE,4'hF,4'h7};

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r = 4'h0;
    logic [3:0] x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r ^= x;
      x = x[3] ? ({x[2:0],1'b0} ^ 4'h3) : {x[2:0],1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] sub16(input logic [15:0] s);
    return {sbx[s[15:12]], sbx[s[11:8]], sbx[s[7:4]], sbx[s[3:0]]};
  endfunction

  function automatic logic [7:0] g(input logic [7:0] w, input logic [7:0] rc);
    return rc ^ {sbx[w[3:0]], sbx[w[7:4]]};
  endfunction

  function automatic logic [15:0] enc(input logic [15:0] pt, input logic [15:0] key);
    logic [7:0] w0, w1, w2, w3, w4, w5;
    logic [15:0] s;
    w0 = key[15:8]; w1 = key[7:0];
    w2 = w0 ^ g(w1, 8'h80); w3 = w2 ^ w1;
    w4 = w2 ^ g(w3, 8'h30); w5 = w4 ^ w3;
    s = pt ^ key;
    s = sub16(s);
    s = {s[15:12], s[3:0], s[7:4], s[11:8]};
    s = {s[15:12] ^ gmul(4'h4, s[11:8]), gmul(4'h4, s[15:12]) ^ s[11:8],
         s[7:4]   ^ gmul(4'h4, s[3:0]),  gmul(4'h4, s[7:4])   ^ s[3:0]};
    s = s ^ {w2, w3};
    s = sub16(s);
    s = {s[15:12], s[3:0], s[7:4], s[11:8]};
    return s ^ {w4, w5};
  endfunction

  // ---------------- checking
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every out_valid pulse must match the head of the scoreboard
  // both in data and in the cycle it was due.
  always @(negedge clk) begin
    if (out_valid && prev_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL valid_consecutive: out_valid high two cycles at cycle %0d", cyc);
    end
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_valid: data %h at cycle %0d", out_data, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_cmp++;
        if (out_data !== e.data || cyc != e.due) begin
          n_fail++;
          $display("FAIL result: got %h at cycle %0d expected %h at cycle %0d",
                   out_data, cyc, e.data, e.due);
        end
      end
    end else if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp++; n_fail++;
      $display("FAIL result_timeout: expected %h due at cycle %0d, none by %0d", e.data, e.due, cyc);
    end
    prev_valid = out_valid;
  end

  // ---------------- stimulus
  // Called just after a clock edge. Drives hi bytes, optionally stalls,
  // then lo bytes; the result is due 4 edges after the lo-byte edge.
  task automatic load(input logic [15:0] c, input logic [15:0] k,
                      input bit push, input logic [15:0] pt, input int stall);
    exp_t e;
    en = 1'b1; c_in = c[15:8]; k_in = k[15:8];
    @(posedge clk); #1;
    chk("busy_after_hi", {15'd0, out_busy}, 16'd1);
    en = 1'b0; c_in = 8'hxx; k_in = 8'hxx;
    repeat (stall) begin
      c_in = 8'hEE; k_in = 8'hDD;
      @(posedge clk); #1;
    end
    en = 1'b1; c_in = c[7:0]; k_in = k[7:0];
    @(posedge clk); #1;
    en = 1'b0; c_in = 8'h00; k_in = 8'h00;
    if (push) begin
      e.data = pt; e.due = cyc + 4;
      sb_q.push_back(e);
    end
  endtask

  initial begin
    logic [15:0] pt, key;
    rst = 1'b1; en = 1'b0; c_in = 8'h00; k_in = 8'h00;

    // 1 reset
    repeat (2) @(posedge clk); #1;
    chk("reset_data",  out_data, 16'h0000);
    chk("reset_valid", {15'd0, out_valid}, 16'd0);
    chk("reset_busy",  {15'd0, out_busy},  16'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 2 golden
    load(16'h0738, 16'hA73B, 1'b1, 16'h6F6B, 0);
    chk("busy_keyexp", {15'd0, out_busy}, 16'd1);
    repeat (4) @(posedge clk); #1;
    chk("golden_data",  out_data, 16'h6F6B);
    chk("busy_done",    {15'd0, out_busy}, 16'd0);
    repeat (2) @(posedge clk); #1;

    // 3 load stall
    load(16'h0738, 16'hA73B, 1'b1, 16'h6F6B, 3);
    repeat (4) @(posedge clk); #1;
    chk("stall_data", out_data, 16'h6F6B);
    repeat (2) @(posedge clk); #1;

    // 4 busy ignore: noise during RND2 / RND1 / FINAL
    load(16'h0738, 16'hA73B, 1'b1, 16'h6F6B, 0);
    @(posedge clk); #1;                               // RND2
    en = 1'b1; c_in = 8'hFF; k_in = 8'hFF;
    @(posedge clk); #1;                               // RND1
    en = 1'b0; c_in = 8'h12; k_in = 8'h34;
    @(posedge clk); #1;                               // FINAL
    en = 1'b1; c_in = 8'h55; k_in = 8'hAA;
    @(posedge clk); #1;                               // IDLE, pulse
    en = 1'b0;
    chk("ignore_data", out_data, 16'h6F6B);
    chk("ignore_busy", {15'd0, out_busy}, 16'd0);
    repeat (4) @(posedge clk); #1;
    chk("ignore_hold", out_data, 16'h6F6B);

    // 5 reset during RND1
    load(16'h1234, 16'h5678, 1'b0, 16'h0000, 0);
    repeat (2) @(posedge clk); #1;                    // now in RND1
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_data",  out_data, 16'h0000);
    chk("midrst_busy",  {15'd0, out_busy},  16'd0);
    chk("midrst_valid", {15'd0, out_valid}, 16'd0);
    repeat (6) @(posedge clk); #1;
    chk("midrst_hold", out_data, 16'h0000);
    load(16'h0738, 16'hA73B, 1'b1, 16'h6F6B, 0);
    repeat (4) @(posedge clk); #1;
    chk("midrst_golden", out_data, 16'h6F6B);

    // 6 round-trip, back to back
    for (int i = 0; i < 256; i++) begin
      pt  = 16'($urandom);
      key = 16'($urandom);
      load(enc(pt, key), key, 1'b1, pt, 0);
      repeat (4) @(posedge clk); #1;
    end

    repeat (8) @(posedge clk); #1;
    if (sb_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain: %0d results never seen", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
